// File: rtl/audio_pkg.sv
// Shared definitions for the speaker output path.
//   mix_state_t : sequencer states of the channel mixer
//   MID_LEVEL   : mid-scale (silent) PWM level for the default 8-bit PWM
//   GAIN_FULL   : unity fade gain for the default 4-bit fade resolution
//   sample_t    : default-width signed audio sample
package audio_pkg;

    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_PWM_W     = 8;
    localparam int DEF_FADE_BITS = 4;

    localparam logic [DEF_PWM_W-1:0] MID_LEVEL = {1'b1, {(DEF_PWM_W-1){1'b0}}};
    localparam int                   GAIN_FULL = 2**DEF_FADE_BITS;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } mix_state_t;

endpackage

// File: rtl/audio_pwm_core.sv
// PWM generator with a double-buffered level.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   level_in/load_in : new offset-binary level, strobe to latch it as pending
//   level_out        : level driving the current PWM period
//   pwm_out          : registered PWM output, high while count < level_out
// The pending level is promoted only when the free-running counter wraps,
// so each period is always generated from a single level.
module audio_pwm_core #(
    parameter int PWM_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [PWM_W-1:0] level_in,
    input  logic             load_in,
    output logic [PWM_W-1:0] level_out,
    output logic             pwm_out
);

    localparam logic [PWM_W-1:0] MID = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W-1:0] count;
    logic [PWM_W-1:0] pend_q;
    logic [PWM_W-1:0] level_q;
    logic             pwm_q;
    logic             wrap;

    assign wrap = &count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count   <= '0;
            pend_q  <= MID;
            level_q <= MID;
            pwm_q   <= 1'b0;
        end else begin
            count <= count + PWM_W'(1);
            if (load_in)
                pend_q <= level_in;
            // A level arriving on the wrap cycle itself is taken directly so
            // it is not held back a whole extra period.
            if (wrap)
                level_q <= load_in ? level_in : pend_q;
            pwm_q <= (count < level_q);
        end
    end

    assign level_out = level_q;
    assign pwm_out   = pwm_q;

endmodule

// File: rtl/audio_out_mixer.sv
// Multi-channel audio mixer feeding the speaker PWM.
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   sample_in            : NUM_CH signed samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   sample_valid_in      : strobe, accepted only while sample_ready_out is high
//   sample_ready_out     : high in IDLE
//   ch_en_in             : per-channel enable, drives the fade gain up/down
//   vol_in               : per-channel 3-bit volume, sample >>> (7-vol)
//   clip_clr_in          : clears the sticky clip flag (a clamp wins)
//   clip_out             : sticky saturation flag
//   level_out            : offset-binary level driving the PWM
//   done_out             : one-cycle pulse when a new level is pending
//   pwm_out              : registered PWM output
// Optional build macro AUDIO_NOISE_SHAPE_EN adds first-order error feedback
// of the truncated LSBs into the next mix.
module audio_out_mixer
    import audio_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int SAMPLE_W  = 16,
    parameter int PWM_W     = 8,
    parameter int FADE_BITS = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid_in,
    output logic                       sample_ready_out,
    input  logic [NUM_CH-1:0]          ch_en_in,
    input  logic [NUM_CH*3-1:0]        vol_in,
    input  logic                       clip_clr_in,
    output logic                       clip_out,
    output logic [PWM_W-1:0]           level_out,
    output logic                       done_out,
    output logic                       pwm_out
);

    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int G_W    = FADE_BITS + 1;
    localparam int WIDE_W = ACC_W + G_W + 1;

    localparam logic [G_W-1:0]          G_MAX = {1'b1, {FADE_BITS{1'b0}}};
    localparam logic [PWM_W-1:0]        MID   = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    mix_state_t                       state;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  x_q;
    logic [NUM_CH-1:0][2:0]           vol_q;
    logic [NUM_CH-1:0][G_W-1:0]       gain_q;
    logic [NUM_CH-1:0][G_W-1:0]       gain_nxt;
    logic [CH_W-1:0]                  ch_idx;
    logic signed [ACC_W-1:0]          acc_q;
    logic [PWM_W-1:0]                 level_q;
    logic                             ready_q;
    logic                             done_q;
    logic                             clip_q;
    logic                             last_ch;

    // Fade gain step taken on accept; the stepped gain already applies to
    // the sample being accepted.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            gain_nxt[k] = gain_q[k];
            if (ch_en_in[k]) begin
                if (gain_q[k] != G_MAX)
                    gain_nxt[k] = gain_q[k] + G_W'(1);
            end else if (gain_q[k] != '0) begin
                gain_nxt[k] = gain_q[k] - G_W'(1);
            end
        end
    end

    // One channel term per ACC cycle.
    logic signed [SAMPLE_W-1:0] x_sel;
    logic signed [SAMPLE_W-1:0] x_shift;
    logic [2:0]                 shamt;
    logic signed [WIDE_W-1:0]   prod;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    acc_sum;
    logic                       clamp;
    logic [PWM_W-1:0]           level_nxt;

    always_comb begin
        x_sel   = x_q[ch_idx];
        shamt   = 3'd7 - vol_q[ch_idx];
        x_shift = x_sel >>> shamt;
        prod    = WIDE_W'(x_shift) * WIDE_W'($signed({1'b0, gain_q[ch_idx]}));
        term    = ACC_W'(prod >>> FADE_BITS);
        acc_sum = acc_q + term;
    end

    assign last_ch = (ch_idx == CH_W'(NUM_CH - 1));

`ifdef AUDIO_NOISE_SHAPE_EN
    localparam int RES_W = SAMPLE_W - PWM_W;

    logic [RES_W-1:0]           residue_q;
    logic [SAMPLE_W-1:0]        sat_s;
    logic signed [SAMPLE_W:0]   shaped;

    // Saturate, then fold in last mix's discarded LSBs. The residue is
    // non-negative so only the positive rail can be crossed again, and that
    // re-clamp is not a clip event.
    always_comb begin
        clamp = 1'b0;
        sat_s = acc_sum[SAMPLE_W-1:0];
        if (acc_sum > S_MAX) begin
            clamp = 1'b1;
            sat_s = S_MAX[SAMPLE_W-1:0];
        end else if (acc_sum < S_MIN) begin
            clamp = 1'b1;
            sat_s = S_MIN[SAMPLE_W-1:0];
        end
        shaped = $signed({sat_s[SAMPLE_W-1], sat_s}) + $signed({1'b0, {PWM_W{1'b0}}, residue_q});
        if (shaped > $signed({2'b00, {(SAMPLE_W-1){1'b1}}}))
            shaped = {2'b00, {(SAMPLE_W-1){1'b1}}};
        level_nxt = shaped[SAMPLE_W-1 -: PWM_W] ^ MID;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            residue_q <= '0;
        else if (state == ACC && last_ch)
            residue_q <= shaped[RES_W-1:0];
    end
`else
    // Saturate and truncate. The rails map straight to full/zero level;
    // otherwise the top bits with the sign flipped give offset binary.
    always_comb begin
        clamp     = 1'b0;
        level_nxt = acc_sum[SAMPLE_W-1 -: PWM_W] ^ MID;
        if (acc_sum > S_MAX) begin
            clamp     = 1'b1;
            level_nxt = {PWM_W{1'b1}};
        end else if (acc_sum < S_MIN) begin
            clamp     = 1'b1;
            level_nxt = '0;
        end
    end
`endif

    // Sequencer. The final channel's add and the clamp resolve on the edge
    // into SAT, so level, clip and done_out all appear in the SAT cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            clip_q  <= 1'b0;
            x_q     <= '0;
            vol_q   <= '0;
            gain_q  <= '0;
            ch_idx  <= '0;
            acc_q   <= '0;
            level_q <= MID;
        end else begin
            done_q <= 1'b0;
            if (clip_clr_in)
                clip_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid_in && ready_q) begin
                        x_q     <= sample_in;
                        vol_q   <= vol_in;
                        gain_q  <= gain_nxt;
                        acc_q   <= '0;
                        ch_idx  <= '0;
                        ready_q <= 1'b0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    acc_q  <= acc_sum;
                    ch_idx <= ch_idx + CH_W'(1);
                    if (last_ch) begin
                        level_q <= level_nxt;
                        done_q  <= 1'b1;
                        if (clamp)
                            clip_q <= 1'b1;
                        state <= SAT;
                    end
                end
                SAT: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    audio_pwm_core #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .level_in  (level_q),
        .load_in   (done_q),
        .level_out (level_out),
        .pwm_out   (pwm_out)
    );

    assign sample_ready_out = ready_q;
    assign done_out         = done_q;
    assign clip_out         = clip_q;

endmodule

// File: tb/tb_audio_out_mixer.sv
module tb_audio_out_mixer;

    localparam int NUM_CH = 2;
    localparam int SW     = 16;
    localparam int PW     = 8;
    localparam int FB     = 4;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in = 1'b1;
    logic [NUM_CH*SW-1:0]  sample_in = '0;
    logic                  sample_valid_in = 1'b0;
    logic                  sample_ready_out;
    logic [NUM_CH-1:0]     ch_en_in = '0;
    logic [NUM_CH*3-1:0]   vol_in = '0;
    logic                  clip_clr_in = 1'b0;
    logic                  clip_out;
    logic [PW-1:0]         level_out;
    logic                  done_out;
    logic                  pwm_out;

    always #5 clk_in = ~clk_in;

    audio_out_mixer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .PWM_W(PW), .FADE_BITS(FB)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .ch_en_in         (ch_en_in),
        .vol_in           (vol_in),
        .clip_clr_in      (clip_clr_in),
        .clip_out         (clip_out),
        .level_out        (level_out),
        .done_out         (done_out),
        .pwm_out          (pwm_out)
    );

    int vectors = 0;
    int errors  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Period counter, levels, flags kept as plain integers; the mix result
    // is computed with integer arithmetic straight from the formula.
    int m_cnt, m_lvl, m_pend, m_pwm, m_done, m_clip, m_busy, m_pcnt;
    int m_q_lvl, m_q_clamp;
    int m_g[NUM_CH];

    task automatic model_reset();
        m_cnt = 0; m_lvl = 'h80; m_pend = 'h80; m_pwm = 0; m_done = 0;
        m_clip = 0; m_busy = 0; m_pcnt = 0; m_q_lvl = 'h80; m_q_clamp = 0;
        for (int k = 0; k < NUM_CH; k++) m_g[k] = 0;
    endtask

    task automatic model_step();
        bit acc_ok;
        bit clamp_now;
        int x, v, t, sum;
        acc_ok = sample_valid_in && (m_busy == 0);
        m_pwm = (m_cnt < m_lvl) ? 1 : 0;
        if (m_cnt == 255) m_lvl = m_pend;
        m_cnt = (m_cnt + 1) % 256;
        m_done = 0;
        clamp_now = 0;
        if (m_pcnt > 0) begin
            m_pcnt--;
            if (m_pcnt == 0) begin
                m_done = 1;
                m_pend = m_q_lvl;
                clamp_now = m_q_clamp[0];
            end
        end
        if (clamp_now) m_clip = 1;
        else if (clip_clr_in) m_clip = 0;
        if (m_busy > 0) m_busy--;
        if (acc_ok) begin
            sum = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_en_in[k]) m_g[k] = (m_g[k] < 16) ? m_g[k] + 1 : 16;
                else             m_g[k] = (m_g[k] > 0) ? m_g[k] - 1 : 0;
                x = $signed(sample_in[k*SW +: SW]);
                v = vol_in[k*3 +: 3];
                t = ((x >>> (7 - v)) * m_g[k]) >>> FB;
                sum += t;
            end
            m_q_clamp = (sum > 32767 || sum < -32768) ? 1 : 0;
            if (sum > 32767)  sum = 32767;
            if (sum < -32768) sum = -32768;
            m_q_lvl = (sum + 32768) / 256;
            m_pcnt = 2;
            m_busy = 3;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_in);
            if (cmp_en) begin
                check("ready", sample_ready_out, (m_busy == 0) ? 1 : 0);
                check("done",  done_out,  m_done);
                check("clip",  clip_out,  m_clip);
                check("level", level_out, m_lvl);
                check("pwm",   pwm_out,   m_pwm);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] s0, input logic [15:0] s1,
                        input logic [1:0] en, input logic [2:0] v0, input logic [2:0] v1);
        int n = 0;
        while (sample_ready_out !== 1'b1 && n < 16) begin
            @(negedge clk_in); #1; n++;
        end
        if (n == 16) check("ready_timeout", sample_ready_out, 1);
        sample_in = {s1, s0}; ch_en_in = en; vol_in = {v1, v0};
        sample_valid_in = 1'b1;
        @(negedge clk_in); #1;
        sample_valid_in = 1'b0;
        repeat (3) begin @(negedge clk_in); #1; end
    endtask

    task automatic wait_level(input string name, input int exp);
        int n = 0;
        while (int'(level_out) != exp && n < 600) begin
            @(negedge clk_in); n++;
        end
        check(name, level_out, exp);
        #1;
    endtask

    task automatic count_high(input int cycles, output int h);
        h = 0;
        repeat (cycles) begin
            @(negedge clk_in);
            if (pwm_out) h++;
        end
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors", vectors);
        $fatal(1);
    end

    initial begin
        int h;
        // Reset
        #2 rst_n_in = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_pwm",   pwm_out, 0);
        check("rst_level", level_out, 'h80);
        check("rst_ready", sample_ready_out, 1);
        check("rst_clip",  clip_out, 0);
        check("rst_done",  done_out, 0);
        #1 rst_n_in = 1'b1;
        count_high(256, h);
        check("mid_duty", h, 128);

        // Fade in channel 0, channel 1 disabled
        send(16'h4000, 16'h0000, 2'b01, 3'd7, 3'd7);
        check("model_fade1", m_q_lvl, 'h84);
        wait_level("fade1_level", 'h84);
        repeat (15) send(16'h4000, 16'h0000, 2'b01, 3'd7, 3'd7);
        check("model_fade16", m_q_lvl, 'hC0);
        wait_level("fade16_level", 'hC0);
        repeat (16) send(16'h4000, 16'h0000, 2'b00, 3'd7, 3'd7);
        check("model_fadeout", m_q_lvl, 'h80);
        wait_level("fadeout_level", 'h80);

        // Positive saturation, both channels ramped to full gain
        repeat (16) send(16'h7000, 16'h7000, 2'b11, 3'd7, 3'd7);
        check("model_posclamp", m_q_lvl, 'hFF);
        wait_level("posclamp_level", 'hFF);
        check("clip_set", clip_out, 1);
        count_high(256, h);
        check("full_duty", h, 255);
        check("clip_held", clip_out, 1);
        clip_clr_in = 1'b1;
        @(negedge clk_in); #1;
        clip_clr_in = 1'b0;
        check("clip_cleared", clip_out, 0);

        // Clamp against a held clear; valid held through ACC is ignored
        clip_clr_in = 1'b1;
        sample_in = {16'h7000, 16'h7000}; ch_en_in = 2'b11; vol_in = {3'd7, 3'd7};
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        check("lat_c1_done", done_out, 0);
        @(negedge clk_in);
        check("lat_c2_done", done_out, 0);
        @(negedge clk_in);
        check("lat_c3_done", done_out, 1);
        check("clamp_beats_clr", clip_out, 1);
        #1 sample_valid_in = 1'b0;
        @(negedge clk_in);
        check("clr_after_clamp", clip_out, 0);
        #1 clip_clr_in = 1'b0;

        // Negative saturation
        send(16'h9000, 16'h9000, 2'b11, 3'd7, 3'd7);
        check("model_negclamp", m_q_lvl, 'h00);
        wait_level("negclamp_level", 'h00);
        count_high(256, h);
        check("zero_duty", h, 0);
        check("neg_clip", clip_out, 1);

        // Mixed volumes: 0x4000>>>4=0x400, -0x4000>>>2=-0x1000 -> -0xC00
        send(16'h4000, 16'hC000, 2'b11, 3'd3, 3'd5);
        check("model_vol", m_q_lvl, 'h74);
        wait_level("vol_level", 'h74);
        // Just past the negative rail: -0x8000 + (-0x8000>>>7) = -0x8100
        send(16'h8000, 16'h8000, 2'b11, 3'd7, 3'd0);
        check("model_edgeclamp", m_q_lvl, 'h00);
        wait_level("edgeclamp_level", 'h00);

        // Reset while accumulating
        sample_in = {16'h7000, 16'h7000}; ch_en_in = 2'b11; vol_in = {3'd7, 3'd7};
        sample_valid_in = 1'b1;
        @(negedge clk_in); #1;
        sample_valid_in = 1'b0;
        rst_n_in = 1'b0;
        #1;
        check("abort_level", level_out, 'h80);
        check("abort_ready", sample_ready_out, 1);
        check("abort_clip",  clip_out, 0);
        repeat (3) begin
            @(negedge clk_in);
            check("abort_done", done_out, 0);
        end
        #1 rst_n_in = 1'b1;
        send(16'h4000, 16'h0000, 2'b01, 3'd7, 3'd7);
        check("model_regain", m_q_lvl, 'h84);
        wait_level("regain_level", 'h84);

        repeat (4) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
